voter_session: RTL and testbench



---
 rtl/voter_session.sv | 182 ++++++++++++++++++
 tb/tb_voter_session.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voter_session.sv
// Purpose : gather one ballot per voter over a bounded window, tally yes votes, classify LOW/MID/HIGH.
// Latency : last accepted ballot in OPEN cycle T -> result_vld at T+2 (OPEN -> COUNT -> DONE).
// Backpr. : result held in DONE until result_ack; start ignored outside IDLE. Macro: VOTER_SESSION_REVOTE_EN.
module voter_session #(
   parameter int N_VOTERS = 4,
   parameter int LOW_MAX  = 1,
   parameter int HIGH_MIN = 3,
   parameter int WINDOW   = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [N_VOTERS-1:0]               vote_vld,
   input  logic [N_VOTERS-1:0]               vote_val,
   output logic                              busy,
   output logic                              result_vld,
   input  logic                              result_ack,
   output logic [$clog2(N_VOTERS+1)-1:0]     yes_cnt,
   output logic [$clog2(N_VOTERS+1)-1:0]     cast_cnt,
   output logic [2:0]                        class_o,
   output logic                              timeout,
   output logic                              dup_err
);

   localparam int CW = $clog2(N_VOTERS+1);
   localparam int TW = $clog2(WINDOW);

   localparam logic [2:0] CLS_LOW  = 3'b001;
   localparam logic [2:0] CLS_MID  = 3'b010;
   localparam logic [2:0] CLS_HIGH = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OPEN  = 2'd1,
      S_COUNT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [N_VOTERS-1:0] cast;
   logic [N_VOTERS-1:0] ballot;
   logic [TW-1:0]       timer;

   logic [N_VOTERS-1:0] accept;
   logic [N_VOTERS-1:0] cast_nxt;
   logic [N_VOTERS-1:0] ballot_nxt;
   logic                dup_hit;
   logic                win_end;
   logic                all_in;
   logic                close;
   logic [CW-1:0]       yes_nxt;

   function automatic logic [CW-1:0] popcnt(input logic [N_VOTERS-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < N_VOTERS; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   // HIGH wins over LOW only if thresholds were misconfigured; normally exactly one range matches
   function automatic logic [2:0] class_of(input logic [CW-1:0] y);
      logic [2:0] c;
      if (int'(y) >= HIGH_MIN) begin
         c = CLS_HIGH;
      end else if (int'(y) <= LOW_MAX) begin
         c = CLS_LOW;
      end else begin
         c = CLS_MID;
      end
      return c;
   endfunction

   // Ballot acceptance and close conditions for the current OPEN cycle
   always_comb begin
      accept     = '0;
      dup_hit    = 1'b0;
      all_in     = 1'b0;
`ifdef VOTER_SESSION_REVOTE_EN
      // every strobe overwrites; the window always runs to the end
      accept     = vote_vld;
`else
      // first ballot sticks; repeats are only flagged
      accept     = vote_vld & ~cast;
      dup_hit    = |(vote_vld & cast);
      all_in     = &(cast | vote_vld);
`endif
      cast_nxt   = cast | vote_vld;
      ballot_nxt = (ballot & ~accept) | (vote_val & accept);
      win_end    = (timer == TW'(WINDOW-1));
      close      = win_end | all_in;
      yes_nxt    = popcnt(ballot & cast);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and state-derived handshake outputs
   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      result_vld = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_OPEN;
            end
         end
         S_OPEN: begin
            busy = 1'b1;
            if (close) begin
               state_nxt = S_COUNT;
            end
         end
         S_COUNT: begin
            busy      = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            busy       = 1'b1;
            result_vld = 1'b1;
            // start in the same cycle is deliberately not looked at here
            if (result_ack) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Session datapath: ballot capture, window timer, tally and duplicate flag
   always_ff @(posedge clk) begin
      if (rst) begin
         cast     <= '0;
         ballot   <= '0;
         timer    <= '0;
         yes_cnt  <= '0;
         cast_cnt <= '0;
         class_o  <= '0;
         timeout  <= 1'b0;
         dup_err  <= 1'b0;
      end else begin
         dup_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  cast   <= '0;
                  ballot <= '0;
                  timer  <= '0;
               end
            end
            S_OPEN: begin
               timer   <= timer + TW'(1);
               cast    <= cast_nxt;
               ballot  <= ballot_nxt;
               dup_err <= dup_hit;
            end
            S_COUNT: begin
               yes_cnt  <= yes_nxt;
               cast_cnt <= popcnt(cast);
               timeout  <= ~(&cast);
               class_o  <= class_of(yes_nxt);
            end
            default: begin
               // DONE: result fields hold
            end
         endcase
      end
   end

endmodule

// File: tb/tb_voter_session.sv
// Bench for voter_session with default parameters.
// Table of single-cycle ballot patterns plus hand-written multi-cycle sequences.
// Expected results travel through a queue from stimulus to result check.
module tb_voter_session;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] vote_vld;
   logic [3:0] vote_val;
   logic       busy;
   logic       result_vld;
   logic       result_ack;
   logic [2:0] yes_cnt;
   logic [2:0] cast_cnt;
   logic [2:0] class_o;
   logic       timeout;
   logic       dup_err;

   int total;
   int bad;

`ifdef VOTER_SESSION_REVOTE_EN
   localparam int FULL_LAT = 17;
   localparam logic DUP_EXP = 1'b0;
   localparam logic [2:0] DUP_YES = 3'd0;
`else
   localparam int FULL_LAT = 2;
   localparam logic DUP_EXP = 1'b1;
   localparam logic [2:0] DUP_YES = 3'd1;
`endif
   localparam int TMO_LAT = 17;

   typedef struct {
      logic [2:0] yes;
      logic [2:0] cst;
      logic [2:0] cls;
      logic       tmo;
      int         lat;
   } res_t;

   typedef struct {
      logic [3:0] vld;
      logic [3:0] val;
      res_t       exp;
   } vec_t;

   res_t exp_q[$];
   vec_t tbl[$];

   voter_session dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .vote_vld   (vote_vld),
      .vote_val   (vote_val),
      .busy       (busy),
      .result_vld (result_vld),
      .result_ack (result_ack),
      .yes_cnt    (yes_cnt),
      .cast_cnt   (cast_cnt),
      .class_o    (class_o),
      .timeout    (timeout),
      .dup_err    (dup_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] cls_exp(input int n);
      if (n <= 1) return 3'b001;
      if (n == 2) return 3'b010;
      return 3'b100;
   endfunction

   function automatic res_t mk(input int y, input int c, input logic t, input int lat);
      res_t r;
      r.yes = 3'(y);
      r.cst = 3'(c);
      r.cls = cls_exp(y);
      r.tmo = t;
      r.lat = lat;
      return r;
   endfunction

   task automatic start_session();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // lat0 = steps already taken since the ballot-driving cycle
   task automatic wait_result(input int lat0);
      int   lat;
      res_t e;
      lat = lat0;
      while (!result_vld && lat < 60) begin
         step();
         lat++;
      end
      if (exp_q.size() == 0) begin
         chk("queue_empty", 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      if (!result_vld) begin
         chk("result_timeout", 32'(result_vld), 32'd1);
         return;
      end
      chk("latency",  32'(lat),      32'(e.lat));
      chk("yes_cnt",  32'(yes_cnt),  32'(e.yes));
      chk("cast_cnt", 32'(cast_cnt), 32'(e.cst));
      chk("class_o",  32'(class_o),  32'(e.cls));
      chk("timeout",  32'(timeout),  32'(e.tmo));
      chk("busy_done", 32'(busy),    32'd1);
   endtask

   task automatic ack_result(input logic [2:0] yes_hold);
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      chk("vld_after_ack",  32'(result_vld), 32'd0);
      chk("busy_after_ack", 32'(busy),       32'd0);
      chk("yes_held_idle",  32'(yes_cnt),    32'(yes_hold));
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      start = 1'b0;
      vote_vld = '0;
      vote_val = '0;
      result_ack = 1'b0;

      // table: full-vote sweep plus timeout patterns
      for (int k = 0; k < 16; k++) begin
         vec_t v;
         logic [3:0] kv;
         kv = 4'(k);
         v.vld = 4'b1111;
         v.val = kv;
         v.exp = mk($countones(kv), 4, 1'b0, FULL_LAT);
         tbl.push_back(v);
      end
      begin
         vec_t v;
         v.vld = 4'b0011; v.val = 4'b0011; v.exp = mk(2, 2, 1'b1, TMO_LAT); tbl.push_back(v);
         v.vld = 4'b0000; v.val = 4'b1111; v.exp = mk(0, 0, 1'b1, TMO_LAT); tbl.push_back(v);
         v.vld = 4'b0111; v.val = 4'b1101; v.exp = mk(2, 3, 1'b1, TMO_LAT); tbl.push_back(v);
         v.vld = 4'b1110; v.val = 4'b1111; v.exp = mk(3, 3, 1'b1, TMO_LAT); tbl.push_back(v);
      end

      // reset state
      step();
      step();
      rst = 1'b0;
      chk("rst_busy",     32'(busy),       32'd0);
      chk("rst_vld",      32'(result_vld), 32'd0);
      chk("rst_yes",      32'(yes_cnt),    32'd0);
      chk("rst_cast",     32'(cast_cnt),   32'd0);
      chk("rst_class",    32'(class_o),    32'd0);
      chk("rst_timeout",  32'(timeout),    32'd0);
      chk("rst_dup",      32'(dup_err),    32'd0);
      step();
      chk("idle_busy", 32'(busy), 32'd0);

      // first session, then hold the result without ack
      start_session();
      chk("open_busy", 32'(busy), 32'd1);
      vote_vld = 4'b1111;
      vote_val = 4'b1011;
      exp_q.push_back(mk(3, 4, 1'b0, FULL_LAT));
      step();
      vote_vld = '0;
      wait_result(1);
      for (int c = 0; c < 10; c++) begin
         step();
         chk("hold_vld", 32'(result_vld), 32'd1);
         chk("hold_yes", 32'(yes_cnt),    32'd3);
         chk("hold_cls", 32'(class_o),    32'b100);
      end
      // ack and start together: ack wins, no new session
      result_ack = 1'b1;
      start = 1'b1;
      step();
      result_ack = 1'b0;
      start = 1'b0;
      chk("ackstart_busy", 32'(busy), 32'd0);
      chk("ackstart_vld",  32'(result_vld), 32'd0);
      step();
      chk("ackstart_stay_idle", 32'(busy), 32'd0);
      // ack outside DONE is ignored
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      chk("stray_ack_idle", 32'(busy), 32'd0);

      // table
      for (int i = 0; i < tbl.size(); i++) begin
         start_session();
         vote_vld = tbl[i].vld;
         vote_val = tbl[i].val;
         exp_q.push_back(tbl[i].exp);
         step();
         vote_vld = '0;
         vote_val = '0;
         wait_result(1);
         ack_result(tbl[i].exp.yes);
      end

      // duplicate ballot from voter 2: yes then no
      start_session();
      vote_vld = 4'b0100;
      vote_val = 4'b0100;
      exp_q.push_back(mk(int'(DUP_YES), 1, 1'b1, TMO_LAT));
      step();
      chk("dup_first", 32'(dup_err), 32'd0);
      vote_vld = 4'b0100;
      vote_val = 4'b0000;
      step();
      vote_vld = '0;
      chk("dup_pulse", 32'(dup_err), 32'(DUP_EXP));
      step();
      chk("dup_clear", 32'(dup_err), 32'd0);
      wait_result(3);
      ack_result(DUP_YES);

      // reset in OPEN after two ballots
      start_session();
      vote_vld = 4'b0001;
      vote_val = 4'b0001;
      step();
      vote_vld = 4'b0010;
      vote_val = 4'b0010;
      step();
      vote_vld = '0;
      vote_val = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_busy",    32'(busy),       32'd0);
      chk("mrst_vld",     32'(result_vld), 32'd0);
      chk("mrst_yes",     32'(yes_cnt),    32'd0);
      chk("mrst_cast",    32'(cast_cnt),   32'd0);
      chk("mrst_class",   32'(class_o),    32'd0);
      chk("mrst_timeout", 32'(timeout),    32'd0);
      step();
      chk("mrst_no_result", 32'(result_vld), 32'd0);
      start_session();
      vote_vld = 4'b1000;
      vote_val = 4'b1000;
      exp_q.push_back(mk(1, 1, 1'b1, TMO_LAT));
      step();
      vote_vld = '0;
      vote_val = '0;
      wait_result(1);
      ack_result(3'd1);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
